// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the pipeline hazard controller.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int REG_AW_DEF = 5;

    // Ceiling log2; returns at least 1 so a counter always has one bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hazard_unit_mc_md_busy_counter.sv
// Multiply/divide occupancy scoreboard: a down-counter loaded with the op
// latency on issue; busy while non-zero.
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);

    logic [CNT_W-1:0] r_mdcnt;

    // A start while busy simply reloads the counter (restart).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mdcnt <= '0;
        end else if (start) begin
            r_mdcnt <= is_div ? DIV_LOAD : MUL_LOAD;
        end else if (r_mdcnt != '0) begin
            r_mdcnt <= r_mdcnt - 1'b1;
        end
    end

    assign busy = (r_mdcnt != '0);

endmodule

// File: rtl/hazard_unit_mc.sv
// 5-stage MIPS hazard controller: forwarding selects, load-use / branch /
// mult-div stalls, and a saturating stall-cycle counter.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              branchD,
    input  logic              mdopD,
    input  logic              mfhiloD,
    input  logic              mdstartE,
    input  logic              mddivE,
    output logic              stallF,
    output logic              stallD,
    output logic              flushE,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              mdbusy,
    output logic [PERF_W-1:0] stall_cycles
);

    logic [REG_AW-1:0] w_src_e [2];
    logic [REG_AW-1:0] w_src_d [2];
    logic [1:0]        w_fwd_e [2];
    logic              w_fwd_d [2];
    logic              w_lwstall;
    logic              w_branchstall;
    logic              w_mdstall;
    logic              w_stall;
    logic              w_mdbusy;
    logic              w_e_hit;
    logic              w_m_hit;
    logic [PERF_W-1:0] r_stall_cycles;

    md_busy_counter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  (mdstartE),
        .is_div (mddivE),
        .busy   (w_mdbusy)
    );

    assign w_src_e[0] = rsE;
    assign w_src_e[1] = rtE;
    assign w_src_d[0] = rsD;
    assign w_src_d[1] = rtD;

    // Operand 0 is A (rs), operand 1 is B (rt); M takes priority over W.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                w_fwd_e[gi] = FWD_REG;
                if (w_src_e[gi] != '0 && w_src_e[gi] == writeregM && regwriteM) begin
                    w_fwd_e[gi] = FWD_MEM;
                end else if (w_src_e[gi] != '0 && w_src_e[gi] == writeregW && regwriteW) begin
                    w_fwd_e[gi] = FWD_WB;
                end
            end
            assign w_fwd_d[gi] = (w_src_d[gi] != '0) && (w_src_d[gi] == writeregM) && regwriteM;
        end
    endgenerate

    assign w_lwstall = memtoregE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));

    // A load in M cannot be forwarded to the D-stage comparator, so it stalls too.
    assign w_e_hit = regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
    assign w_m_hit = memtoregM && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD));
    assign w_branchstall = branchD && (w_e_hit || w_m_hit);

    assign w_mdstall = (w_mdbusy || mdstartE) && (mfhiloD || mdopD);
    assign w_stall   = (w_lwstall || w_branchstall || w_mdstall) && !reset;

    assign stallF    = w_stall;
    assign stallD    = w_stall;
    assign flushE    = w_stall;
    assign forwardAE = reset ? FWD_REG : w_fwd_e[0];
    assign forwardBE = reset ? FWD_REG : w_fwd_e[1];
    assign forwardAD = w_fwd_d[0] && !reset;
    assign forwardBD = w_fwd_d[1] && !reset;
    assign mdbusy    = w_mdbusy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc (perf counter narrowed to 4 bits).
module tb_hazard_unit_mc;

    localparam int REG_AW = 5;
    localparam int PERF_W = 4;

    logic              clk;
    logic              reset;
    logic [REG_AW-1:0] rsD, rtD, rsE, rtE;
    logic [REG_AW-1:0] writeregE, writeregM, writeregW;
    logic              regwriteE, regwriteM, regwriteW;
    logic              memtoregE, memtoregM;
    logic              branchD, mdopD, mfhiloD, mdstartE, mddivE;
    logic              stallF, stallD, flushE, forwardAD, forwardBD;
    logic [1:0]        forwardAE, forwardBE;
    logic              mdbusy;
    logic [PERF_W-1:0] stall_cycles;

    int checks_cnt;
    int errors_cnt;

    hazard_unit_mc #(
        .REG_AW  (REG_AW),
        .MUL_LAT (4),
        .DIV_LAT (32),
        .PERF_W  (PERF_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rsD          (rsD),
        .rtD          (rtD),
        .rsE          (rsE),
        .rtE          (rtE),
        .writeregE    (writeregE),
        .writeregM    (writeregM),
        .writeregW    (writeregW),
        .regwriteE    (regwriteE),
        .regwriteM    (regwriteM),
        .regwriteW    (regwriteW),
        .memtoregE    (memtoregE),
        .memtoregM    (memtoregM),
        .branchD      (branchD),
        .mdopD        (mdopD),
        .mfhiloD      (mfhiloD),
        .mdstartE     (mdstartE),
        .mddivE       (mddivE),
        .stallF       (stallF),
        .stallD       (stallD),
        .flushE       (flushE),
        .forwardAD    (forwardAD),
        .forwardBD    (forwardBD),
        .forwardAE    (forwardAE),
        .forwardBE    (forwardBE),
        .mdbusy       (mdbusy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic clear_inputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0;
        branchD = 1'b0; mdopD = 1'b0; mfhiloD = 1'b0;
        mdstartE = 1'b0; mddivE = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        clear_inputs();
        reset = 1'b1;

        // Reset: a forwarding/stall pattern is present but must be masked.
        rsE = 5'd3; writeregM = 5'd3; regwriteM = 1'b1;
        memtoregE = 1'b1; rtE = 5'd3; rsD = 5'd3;
        #12;
        check("rst_forwardAE", 32'(forwardAE), 32'h0);
        check("rst_stallD", 32'(stallD), 32'h0);
        check("rst_mdbusy", 32'(mdbusy), 32'h0);
        check("rst_stall_cycles", 32'(stall_cycles), 32'h0);
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;

        // Forwarding priority
        rsE = 5'd3; writeregM = 5'd3; regwriteM = 1'b1; writeregW = 5'd3; regwriteW = 1'b1;
        #1 check("fwdAE_mem", 32'(forwardAE), 32'h2);
        regwriteM = 1'b0;
        #1 check("fwdAE_wb", 32'(forwardAE), 32'h1);
        rsE = 5'd0;
        #1 check("fwdAE_zero", 32'(forwardAE), 32'h0);
        rtE = 5'd3; regwriteM = 1'b1;
        #1 check("fwdBE_mem", 32'(forwardBE), 32'h2);
        check("fwd_nostall", 32'(stallD), 32'h0);

        // Load-use
        @(negedge clk);
        clear_inputs();
        memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
        #1 check("lw_stallF", 32'(stallF), 32'h1);
        check("lw_stallD", 32'(stallD), 32'h1);
        check("lw_flushE", 32'(flushE), 32'h1);
        @(negedge clk);
        check("lw_cnt1", 32'(stall_cycles), 32'h1);
        rtE = 5'd0; rsD = 5'd0;
        #1 check("lw_rt0_nostall", 32'(stallD), 32'h0);

        // Branch after load in M, then ALU result in M, then ALU result in E
        @(negedge clk);
        clear_inputs();
        branchD = 1'b1; memtoregM = 1'b1; regwriteM = 1'b1; writeregM = 5'd7; rtD = 5'd7;
        #1 check("br_ldM_stall", 32'(stallD), 32'h1);
        @(negedge clk);
        memtoregM = 1'b0;
        #1 check("br_aluM_nostall", 32'(stallD), 32'h0);
        check("br_forwardBD", 32'(forwardBD), 32'h1);
        check("br_forwardAD", 32'(forwardAD), 32'h0);
        regwriteE = 1'b1; writeregE = 5'd4; rsD = 5'd4;
        #1 check("br_aluE_stall", 32'(stallD), 32'h1);
        @(negedge clk);
        check("br_cnt3", 32'(stall_cycles), 32'h3);

        // Multiply then mfhi
        pulse_reset();
        mfhiloD = 1'b1; mdstartE = 1'b1; mddivE = 1'b0;
        #1 check("mul_issue_stall", 32'(stallD), 32'h1);
        check("mul_issue_busy", 32'(mdbusy), 32'h0);
        @(negedge clk);
        mdstartE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("mul_busy_c%0d", i + 1), 32'(mdbusy), 32'h1);
            check($sformatf("mul_stall_c%0d", i + 1), 32'(stallD), 32'h1);
            @(negedge clk);
        end
        check("mul_done_busy", 32'(mdbusy), 32'h0);
        check("mul_done_stall", 32'(stallD), 32'h0);
        check("mul_cnt5", 32'(stall_cycles), 32'h5);

        // Divide then mfhi; the 4-bit counter saturates along the way
        @(negedge clk);
        mdstartE = 1'b1; mddivE = 1'b1;
        @(negedge clk);
        mdstartE = 1'b0; mddivE = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1 check($sformatf("div_busy_c%0d", i + 1), 32'(mdbusy & stallD), 32'h1);
            @(negedge clk);
        end
        check("div_done_busy", 32'(mdbusy), 32'h0);
        check("div_done_stall", 32'(stallD), 32'h0);
        check("div_cnt_sat", 32'(stall_cycles), 32'hF);

        // Reset mid-divide
        pulse_reset();
        mfhiloD = 1'b1; mdstartE = 1'b1; mddivE = 1'b1;
        @(negedge clk);
        mdstartE = 1'b0; mddivE = 1'b0;
        repeat (10) @(negedge clk);
        check("rstdiv_pre_busy", 32'(mdbusy), 32'h1);
        check("rstdiv_pre_cnt", 32'(stall_cycles), 32'hB);
        #2 reset = 1'b1;
        #1 check("rstdiv_busy", 32'(mdbusy), 32'h0);
        check("rstdiv_stall", 32'(stallD), 32'h0);
        check("rstdiv_flush", 32'(flushE), 32'h0);
        check("rstdiv_cnt", 32'(stall_cycles), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("rstdiv_after_stall", 32'(stallD), 32'h0);

        // Perf saturation with a held load-use stall
        @(negedge clk);
        clear_inputs();
        memtoregE = 1'b1; rtE = 5'd9; rtD = 5'd9;
        repeat (10) @(negedge clk);
        check("sat_cnt10", 32'(stall_cycles), 32'hA);
        repeat (10) @(negedge clk);
        check("sat_cnt20", 32'(stall_cycles), 32'hF);
        check("sat_still_stall", 32'(stallD), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Pipeline hazard controller for the 5-stage MIPS core. It extends the single-issue forwarding/stall logic with a parametrised register-address width and corrected branch-after-load detection. It also adds a cycle-counted scoreboard for the multi-cycle multiply/divide unit (HI/LO) and a saturating stall-cycle performance counter. It sits beside the datapath and drives the F/D stall enables, the E flush, and the forwarding mux selects.

## Interface
- REG_AW, 5: register address width; register 0 is hard-wired zero.
- MUL_LAT, 4: multiply latency in cycles (≥1).
- DIV_LAT, 32: divide latency in cycles (≥1).
- PERF_W, 32: stall-counter width.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rsD, rtD, rsE, rtE  in  REG_AW each  source register numbers in D and E.
- writeregE, writeregM, writeregW  in  REG_AW each  destination register in E/M/W.
- regwriteE, regwriteM, regwriteW  in  1 each  destination write enable per stage.
- memtoregE, memtoregM  in  1 each  load instruction in E/M.
- branchD  in  1  branch (compare in D) in decode.
- mdopD  in  1  D holds mult/div/mthi/mtlo.
- mfhiloD  in  1  D holds mfhi/mflo.
- mdstartE  in  1  E holds a mult/div being issued this cycle.
- mddivE  in  1  qualifies mdstartE: 1 = divide, 0 = multiply.
- stallF, stallD  out  1 each  hold the PC / IF-ID register.
- flushE  out  1  bubble into ID-EX.
- forwardAD, forwardBD  out  1 each  forward ALUOutM to branch comparator.
- forwardAE, forwardBE  out  2 each  E operand select: 00 regfile, 01 ResultW, 10 ALUOutM.
- mdbusy  out  1  multiply/divide unit occupied.
- stall_cycles  out  PERF_W  count of cycles with stallD=1.

## Operation
- forwardAE: 10 if rsE≠0 & rsE==writeregM & regwriteM; else 01 if rsE≠0 & rsE==writeregW & regwriteW; else 00. M has priority over W. forwardBE is identical using rtE.
- forwardAD = rsD≠0 & rsD==writeregM & regwriteM. forwardBD is the same using rtD.
- lwstall = memtoregE & rtE≠0 & (rsD==rtE | rtD==rtE).
- branchstall = branchD & [(regwriteE & writeregE≠0 & writeregE∈{rsD,rtD}) | (memtoregM & writeregM≠0 & writeregM∈{rsD,rtD})].
- mdstall = (mdbusy | mdstartE) & (mfhiloD | mdopD).
- stall = lwstall | branchstall | mdstall. stallF = stallD = flushE = stall.
- MD scoreboard: down-counter mdcnt, CNT_W = clog2(max(MUL_LAT,DIV_LAT)+1) bits.
  - On an edge with mdstartE=1, mdcnt loads DIV_LAT if mddivE=1, else MUL_LAT. A start while already busy reloads the counter (restart); this is legal but never occurs when the stall logic is obeyed.
  - Otherwise, if mdcnt≠0, it decrements. mdbusy = (mdcnt≠0).
- Perf counter: stall_cycles increments on every edge where stallD=1, and saturates at 2^PERF_W−1.

## Timing
- Reset values: mdcnt=0, mdbusy=0, stall_cycles=0. While reset=1, stallF/stallD/flushE are forced 0 and the forward selects are forced 00.
- Forwarding and stall outputs are combinational from the current-cycle inputs plus mdcnt, with zero latency.
- Multiply issued in E on edge t: mdbusy=1 for MUL_LAT cycles after t. An mfhi in D is stalled through the cycle of edge t and those MUL_LAT cycles, then proceeds on the next edge. Divide behaves the same with DIV_LAT.
- MUL_LAT=1: mdbusy is high for exactly one cycle.
- Reset asserted mid-operation clears mdcnt immediately (asynchronous); outputs drop the same cycle.
- All stall conditions are OR-combined; a simultaneous lwstall and mdstall gives a single stall with no double counting.

## Structure
- Shared package hazard_pkg holds:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the REG_AW default;
  - the clog2 helper.
- Sub-module md_busy_counter (parameters MUL_LAT, DIV_LAT; ports clk, reset, start, is_div, busy) contains the scoreboard counter. The top level holds the combinational hazard logic and the perf counter.

## Test plan
- Forwarding priority: rsE=3, writeregM=3/regwriteM=1, writeregW=3/regwriteW=1 -> forwardAE=10. Drop regwriteM -> 01. rsE=0 -> 00.
- Load-use: memtoregE=1, rtE=5, rsD=5 -> stallF=stallD=flushE=1 for one cycle. rtE=0 -> no stall.
- Branch after load in M: branchD=1, memtoregM=1, writeregM=7, rtD=7 -> stall=1. With regwriteM=1 and memtoregM=0 -> no stall, forwardBD=1.
- Multiply then mfhi: mdstartE=1, mddivE=0 at edge t, mfhiloD=1 held -> stall during the cycle before t and 4 cycles after; mdbusy deasserts after 4 cycles. Repeat with a divide -> 32 cycles.
- Reset mid-divide: assert reset 10 cycles into a divide -> mdbusy=0 and stall=0 immediately, stall_cycles=0.
- Perf saturation (PERF_W=4): hold a stall for 20 cycles -> stall_cycles stops at 15.
